read_manage: RTL and testbench

READ_MANAGE -- requirements
Module: read_manage

---
 rtl/rm_pkg.sv | 33 +++
 rtl/read_manage_load_extract.sv | 60 ++++++
 rtl/read_manage.sv | 151 +++++++++++++++
 tb/tb_read_manage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rm_pkg.sv
// Shared types for the read_manage slice: access encodings,
// refill FSM states and the load/store classifier.
package rm_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    MT_LDW  = 3'b000,
    MT_STW  = 3'b001,
    MT_LDB  = 3'b010,
    MT_LDH  = 3'b011,
    MT_LDBU = 3'b100,
    MT_LDHU = 3'b101,
    MT_STB  = 3'b110,
    MT_STH  = 3'b111
  } mem_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_load(
    input logic [2:0] t
  );
    return !((t == MT_STW) ||
             (t == MT_STB) ||
             (t == MT_STH));
  endfunction

endpackage

// File: rtl/read_manage_load_extract.sv
// Load extraction: picks word/half/byte from a 128-bit line and extends it.
// Optional RM_ALE_CHECK_EN flags misaligned ld.w/ld.h(u) and zeroes the data.
module load_extract
  import rm_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [3:0]        addr,
  input  logic [2:0]        mtype,
  output logic [WORD_W-1:0] data,
  output logic              ale
);

  logic [31:0] word_v;
  logic [15:0] half_v;
  logic [7:0]  byte_v;
  logic [31:0] ext_v;

  // slice the addressed word, halfword and byte out of the line
  always_comb begin
    word_v = line[{addr[3:2], 5'b0} +: 32];
    half_v = line[{addr[3:1], 4'b0} +: 16];
    byte_v = line[{addr[3:0], 3'b0} +: 8];
  end

  // sign or zero extend according to access type
  always_comb begin
    ext_v = word_v;
    unique case (mem_type_e'(mtype))
      MT_LDB:  ext_v = {{24{byte_v[7]}}, byte_v};
      MT_LDBU: ext_v = {24'h0, byte_v};
      MT_LDH:  ext_v = {{16{half_v[15]}}, half_v};
      MT_LDHU: ext_v = {16'h0, half_v};
      default: ext_v = word_v;
    endcase
  end

`ifdef RM_ALE_CHECK_EN
  logic mis;

  // misalignment check, zeroing the result on fault
  always_comb begin
    mis = 1'b0;
    unique case (mem_type_e'(mtype))
      MT_LDW:  mis = (addr[1:0] != 2'b00);
      MT_LDH:  mis = addr[0];
      MT_LDHU: mis = addr[0];
      default: mis = 1'b0;
    endcase
    ale  = mis;
    data = mis ? 32'h0 : ext_v;
  end
`else
  // low address bits already truncated by the slicing above
  always_comb begin
    ale  = 1'b0;
    data = ext_v;
  end
`endif

endmodule

// File: rtl/read_manage.sv
// Cache read manager: hit-load extraction and 4-beat line refill.
// Optional RM_ALE_CHECK_EN enables misaligned-load detection (ale).
module read_manage
  import rm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               hit_valid,
  input  logic [LINE_W-1:0]  hit_line,
  input  logic               refill_start,
  input  logic [31:0]        req_addr,
  input  logic [2:0]         mem_type,
  input  logic               ret_valid,
  input  logic               ret_last,
  input  logic [WORD_W-1:0]  ret_data,
  output logic [LINE_W-1:0]  r_line,
  output logic               line_valid,
  output logic               load_valid,
  output logic [WORD_W-1:0]  load_data,
  output logic               busy,
  output logic               proto_err,
  output logic               ale
);

  state_e state;
  state_e state_nx;

  logic [1:0]        cnt;
  logic [LINE_W-1:0] line_q;
  logic [3:0]        addr_q;
  logic [2:0]        type_q;
  logic              proto_q;
  logic              hit_pend;
  logic              ale_q;
  logic [WORD_W-1:0] load_q;

  logic              done_ld;
  logic              hit_ld;
  logic              start;
  logic              beat;

  logic [LINE_W-1:0] src_line;
  logic [3:0]        src_addr;
  logic [2:0]        src_type;
  logic [WORD_W-1:0] ext_data;
  logic              ext_ale;

  logic unused_addr;
  assign unused_addr = ^req_addr[31:4];

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next state and per-state outputs
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    line_valid = 1'b0;
    proto_err  = 1'b0;
    done_ld    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (refill_start) state_nx = S_FILL;
      end
      S_FILL: begin
        busy = 1'b1;
        if (ret_valid &&
            (ret_last || cnt == 2'd3))
          state_nx = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        line_valid = 1'b1;
        proto_err  = proto_q;
        done_ld    = is_load(type_q);
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // refill completion reads the assembled line, otherwise the hit line
  always_comb begin
    start  = (state == S_IDLE) && refill_start;
    beat   = (state == S_FILL) && ret_valid;
    hit_ld = (state == S_IDLE) && hit_valid &&
             !refill_start && is_load(mem_type);
    if (state == S_DONE) begin
      src_line = line_q;
      src_addr = addr_q;
      src_type = type_q;
    end else begin
      src_line = hit_line;
      src_addr = req_addr[3:0];
      src_type = mem_type;
    end
  end

  load_extract u_ext (
    .line  (src_line),
    .addr  (src_addr),
    .mtype (src_type),
    .data  (ext_data),
    .ale   (ext_ale)
  );

  // request latch, line assembly and load result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      line_q   <= '0;
      addr_q   <= 4'h0;
      type_q   <= 3'b000;
      proto_q  <= 1'b0;
      hit_pend <= 1'b0;
      ale_q    <= 1'b0;
      load_q   <= '0;
    end else begin
      hit_pend <= hit_ld;
      if (hit_ld) begin
        load_q <= ext_data;
        ale_q  <= ext_ale;
      end
      if (done_ld) load_q <= ext_data;
      if (start) begin
        addr_q  <= req_addr[3:0];
        type_q  <= mem_type;
        line_q  <= '0;
        cnt     <= 2'd0;
        proto_q <= 1'b0;
      end
      if (beat) begin
        line_q[{cnt, 5'b0} +: 32] <= ret_data;
        cnt     <= cnt + 2'd1;
        proto_q <= ret_last && (cnt != 2'd3);
      end
    end
  end

  // outputs: refill load is combinational in DONE, hit load is registered
  always_comb begin
    r_line     = line_q;
    load_valid = done_ld | hit_pend;
    load_data  = done_ld ? ext_data : load_q;
    ale        = done_ld ? ext_ale : (hit_pend & ale_q);
  end

endmodule

// File: tb/tb_read_manage.sv
// Directed self-checking bench for read_manage.
// Expectations follow RM_ALE_CHECK_EN when it is defined.
module tb_read_manage;

  logic         clk;
  logic         rst;
  logic         hit_valid;
  logic [127:0] hit_line;
  logic         refill_start;
  logic [31:0]  req_addr;
  logic [2:0]   mem_type;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic [127:0] r_line;
  logic         line_valid;
  logic         load_valid;
  logic [31:0]  load_data;
  logic         busy;
  logic         proto_err;
  logic         ale;

  int checks;
  int errors;

  read_manage dut (
    .clk          (clk),
    .rst          (rst),
    .hit_valid    (hit_valid),
    .hit_line     (hit_line),
    .refill_start (refill_start),
    .req_addr     (req_addr),
    .mem_type     (mem_type),
    .ret_valid    (ret_valid),
    .ret_last     (ret_last),
    .ret_data     (ret_data),
    .r_line       (r_line),
    .line_valid   (line_valid),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .busy         (busy),
    .proto_err    (proto_err),
    .ale          (ale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic beat(
    input logic [31:0] d,
    input logic        last
  );
    ret_valid = 1'b1;
    ret_data  = d;
    ret_last  = last;
    step();
    ret_valid = 1'b0;
    ret_last  = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    hit_valid    = 1'b0;
    hit_line     = '0;
    refill_start = 1'b0;
    req_addr     = '0;
    mem_type     = 3'b000;
    ret_valid    = 1'b0;
    ret_last     = 1'b0;
    ret_data     = '0;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rline", r_line, 128'h0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_lvalid", load_valid, 1'b0);
    chk("rst_linev", line_valid, 1'b0);
    chk("rst_perr", proto_err, 1'b0);
    chk("rst_ale", ale, 1'b0);
    rst = 1'b0;
    step();

    // hit ld.b, byte 5 = 0x80
    hit_line  = 128'h80;
    hit_line  = hit_line << 40;
    req_addr  = 32'h5;
    mem_type  = 3'b010;
    hit_valid = 1'b1;
    chk("hit_lat0", load_valid, 1'b0);
    step();
    hit_valid = 1'b0;
    chk("hitb_valid", load_valid, 1'b1);
    chk("hitb_data", load_data, 32'hFFFFFF80);
    step();
    chk("hitb_pulse", load_valid, 1'b0);
    chk("hitb_hold", load_data, 32'hFFFFFF80);

    // hit ld.bu same byte
    mem_type  = 3'b100;
    hit_valid = 1'b1;
    step();
    hit_valid = 1'b0;
    chk("hitbu_data", load_data, 32'h00000080);

    // hit ld.w word 2, ld.h half 7
    hit_line  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    req_addr  = 32'h8;
    mem_type  = 3'b000;
    hit_valid = 1'b1;
    step();
    chk("hitw_data", load_data, 32'hCCCCCCCC);
    req_addr = 32'hE;
    mem_type = 3'b011;
    step();
    chk("hith_data", load_data, 32'hFFFFDDDD);

    // hit ld.w misaligned addr 0x2
    req_addr = 32'h2;
    mem_type = 3'b000;
    step();
    hit_valid = 1'b0;
    chk("hitmis_valid", load_valid, 1'b1);
`ifdef RM_ALE_CHECK_EN
    chk("hitmis_ale", ale, 1'b1);
    chk("hitmis_data", load_data, 32'h0);
`else
    chk("hitmis_ale", ale, 1'b0);
    chk("hitmis_data", load_data, 32'hAAAAAAAA);
`endif

    // hit store produces nothing
    mem_type  = 3'b110;
    hit_valid = 1'b1;
    step();
    hit_valid = 1'b0;
    chk("hitst_valid", load_valid, 1'b0);

    // refill ld.hu addr 0x16, gap between beats 2 and 3
    req_addr     = 32'h16;
    mem_type     = 3'b101;
    refill_start = 1'b1;
    step();
    refill_start = 1'b0;
    chk("rf_busy", busy, 1'b1);
    chk("rf_clear", r_line, 128'h0);
    beat(32'h11111111, 1'b0);
    beat(32'h22223333, 1'b0);
    step();
    chk("rf_gap_busy", busy, 1'b1);
    beat(32'h44445555, 1'b0);
    beat(32'h66667777, 1'b1);
    chk("rf_linev", line_valid, 1'b1);
    chk("rf_lvalid", load_valid, 1'b1);
    chk("rf_ldata", load_data, 32'h00002222);
    chk("rf_rline", r_line,
        128'h66667777_44445555_22223333_11111111);
    chk("rf_perr", proto_err, 1'b0);
    chk("rf_done_busy", busy, 1'b1);
    step();
    chk("rf_idle_busy", busy, 1'b0);
    chk("rf_linev_pulse", line_valid, 1'b0);
    chk("rf_lvalid_pulse", load_valid, 1'b0);
    chk("rf_hold", load_data, 32'h00002222);
    chk("rf_rline_hold", r_line,
        128'h66667777_44445555_22223333_11111111);

    // refill st.w, 4th beat without ret_last
    req_addr     = 32'h0;
    mem_type     = 3'b001;
    refill_start = 1'b1;
    step();
    refill_start = 1'b0;
    beat(32'h01020304, 1'b0);
    beat(32'h05060708, 1'b0);
    beat(32'h090A0B0C, 1'b0);
    beat(32'h0D0E0F10, 1'b0);
    chk("st_linev", line_valid, 1'b1);
    chk("st_lvalid", load_valid, 1'b0);
    chk("st_perr", proto_err, 1'b0);
    chk("st_rline", r_line,
        128'h0D0E0F10_090A0B0C_05060708_01020304);
    step();
    chk("st_busy", busy, 1'b0);
    chk("st_ldata_hold", load_data, 32'h00002222);

    // early ret_last on beat 2, ld.w addr 0x4
    req_addr     = 32'h4;
    mem_type     = 3'b000;
    refill_start = 1'b1;
    step();
    refill_start = 1'b0;
    beat(32'hAAAAAAAA, 1'b0);
    beat(32'hBBBBBBBB, 1'b1);
    chk("early_linev", line_valid, 1'b1);
    chk("early_perr", proto_err, 1'b1);
    chk("early_hi", r_line[127:64], 64'h0);
    chk("early_lo", r_line[63:0],
        64'hBBBBBBBB_AAAAAAAA);
    chk("early_ldata", load_data, 32'hBBBBBBBB);
    step();
    chk("early_perr_pulse", proto_err, 1'b0);

    // reset mid refill
    req_addr     = 32'h0;
    mem_type     = 3'b000;
    refill_start = 1'b1;
    step();
    refill_start = 1'b0;
    beat(32'h12345678, 1'b0);
    beat(32'h9ABCDEF0, 1'b0);
    rst       = 1'b1;
    ret_valid = 1'b1;
    ret_data  = 32'hFFFFFFFF;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_linev", line_valid, 1'b0);
    chk("abort_lvalid", load_valid, 1'b0);
    chk("abort_rline", r_line, 128'h0);
    ret_last = 1'b1;
    step();
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    chk("idle_ret_linev", line_valid, 1'b0);
    chk("idle_ret_busy", busy, 1'b0);

    // hit and refill together: refill wins
    hit_line     = 128'hFF;
    req_addr     = 32'h0;
    mem_type     = 3'b010;
    hit_valid    = 1'b1;
    refill_start = 1'b1;
    step();
    refill_start = 1'b0;
    chk("prio_busy", busy, 1'b1);
    chk("prio_lvalid", load_valid, 1'b0);
    step();
    hit_valid = 1'b0;
    chk("fill_hit_ign", load_valid, 1'b0);
    beat(32'h000000F0, 1'b0);
    beat(32'h0, 1'b0);
    beat(32'h0, 1'b0);
    beat(32'h0, 1'b1);
    chk("prio_done_lv", load_valid, 1'b1);
    chk("prio_done_ld", load_data, 32'hFFFFFFF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
